// File: rtl/mem_controller_core.sv
// Data-memory controller: DRAM, camera frame buffer and a small register block.
// Define MEM_ZERO_INIT_EN to zero-initialise DRAM and FB at time 0.
module mem_controller_core #(
    parameter int DATA_WORDS = 1024,
    parameter int FB_WORDS   = 4096,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              we,
    output logic [ADDR_W-1:0] data_out
);

    localparam int DW_AW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int FW_AW = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;

    localparam logic [29:0] DRAM_W = 30'h14000;
    localparam logic [29:0] DRAM_E = DRAM_W + 30'(DATA_WORDS);
    localparam logic [29:0] FB_W   = 30'h20000;
    localparam logic [29:0] FB_E   = FB_W + 30'(FB_WORDS);
    localparam logic [29:0] SCR_W  = 30'h30000;
    localparam logic [29:0] WRC_W  = 30'h30001;
    localparam logic [29:0] ERC_W  = 30'h30002;

    logic [31:0] dram [DATA_WORDS];
    logic [31:0] fb   [FB_WORDS];

    logic [31:0] scratch;
    logic [31:0] wr_count;
    logic [31:0] err_count;

    logic [29:0]      word;
    logic [29:0]      dram_off;
    logic [29:0]      fb_off;
    logic [DW_AW-1:0] dram_idx;
    logic [FW_AW-1:0] fb_idx;
    logic             in_low;
    logic             dram_hit;
    logic             fb_hit;
    logic             scr_hit;
    logic             wrc_hit;
    logic             erc_hit;
    logic             store_hit;
    logic             ro_hit;
    logic             unused_bits;

    // Byte lane bits are dropped; the region must sit below 1 MiB.
    assign word     = address[31:2];
    assign in_low   = (address[31:20] == 12'h000);
    assign dram_off = word - DRAM_W;
    assign fb_off   = word - FB_W;
    assign dram_idx = dram_off[DW_AW-1:0];
    assign fb_idx   = fb_off[FW_AW-1:0];

    assign dram_hit = in_low && (word >= DRAM_W) && (word < DRAM_E);
    assign fb_hit   = in_low && (word >= FB_W) && (word < FB_E);
    assign scr_hit  = in_low && (word == SCR_W);
    assign wrc_hit  = in_low && (word == WRC_W);
    assign erc_hit  = in_low && (word == ERC_W);

    assign store_hit = dram_hit | fb_hit | scr_hit;
    assign ro_hit    = wrc_hit | erc_hit;

    assign unused_bits = ^{address[1:0],
                           dram_off[29:DW_AW],
                           fb_off[29:FW_AW]};

`ifdef MEM_ZERO_INIT_EN
    initial begin
        for (int i = 0; i < DATA_WORDS; i++) dram[i] = '0;
        for (int i = 0; i < FB_WORDS; i++) fb[i] = '0;
    end
`endif

    // Storage arrays carry no reset so they stay inferable as block RAM.
    always_ff @(posedge clk) begin
        if (we && dram_hit) dram[dram_idx] <= data_in;
        if (we && fb_hit) fb[fb_idx] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch   <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (we) begin
            if (scr_hit) scratch <= data_in;
            if (store_hit) begin
                wr_count <= wr_count + 32'd1;
            end else if (!ro_hit) begin
                err_count <= err_count + 32'd1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        unique case (1'b1)
            dram_hit: data_out = dram[dram_idx];
            fb_hit:   data_out = fb[fb_idx];
            scr_hit:  data_out = scratch;
            wrc_hit:  data_out = wr_count;
            erc_hit:  data_out = err_count;
            default:  data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_controller_core.sv
// Scoreboard bench for mem_controller_core against a byte-address memory model.
// Directed test-plan sequence followed by randomized traffic.
module tb_mem_controller_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        we;
    logic [31:0] data_out;

    int checks;
    int errors;

    logic [31:0] exp_q [$];
    logic [31:0] adr_q [$];
    string       tag_q [$];

    logic [31:0] mdl_mem [int unsigned];
    logic [31:0] mdl_scr;
    logic [31:0] mdl_wrc;
    logic [31:0] mdl_erc;

    mem_controller_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 = RAM word, 2 = SCRATCH, 3 = WR_COUNT, 4 = ERR_COUNT, 0 = unmapped
    function automatic int kind(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        if (b >= 32'h50000 && b < 32'h50000 + 4 * 1024) return 1;
        if (b >= 32'h80000 && b < 32'h80000 + 4 * 4096) return 1;
        if (b == 32'hC0000) return 2;
        if (b == 32'hC0004) return 3;
        if (b == 32'hC0008) return 4;
        return 0;
    endfunction

    function automatic void model_read(input logic [31:0] a,
                                       output logic [31:0] e,
                                       output bit k);
        int unsigned key;
        key = a & 32'hFFFF_FFFC;
        e = '0;
        k = 1'b1;
        case (kind(a))
            1: begin
                if (mdl_mem.exists(key)) begin
                    e = mdl_mem[key];
                end else begin
`ifdef MEM_ZERO_INIT_EN
                    e = '0;
`else
                    k = 1'b0;
`endif
                end
            end
            2: e = mdl_scr;
            3: e = mdl_wrc;
            4: e = mdl_erc;
            default: e = '0;
        endcase
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d);
        int unsigned key;
        key = a & 32'hFFFF_FFFC;
        case (kind(a))
            1: begin mdl_mem[key] = d; mdl_wrc = mdl_wrc + 1; end
            2: begin mdl_scr = d; mdl_wrc = mdl_wrc + 1; end
            3, 4: ;
            default: mdl_erc = mdl_erc + 1;
        endcase
    endfunction

    function automatic void push_exp(input logic [31:0] a, input string tag);
        logic [31:0] e;
        bit k;
        model_read(a, e, k);
        if (k) begin
            exp_q.push_back(e);
            adr_q.push_back(a);
            tag_q.push_back(tag);
        end
    endfunction

    // One cycle: drive after the edge, expect pre-edge contents this cycle.
    task automatic op(input logic [31:0] a, input logic [31:0] d,
                      input logic w, input string tag);
        @(posedge clk);
        #1;
        address = a;
        data_in = d;
        we      = w;
        push_exp(a, tag);
        if (w) model_write(a, d);
    endtask

    task automatic mid_reset(input logic [31:0] a, input string tag);
        @(posedge clk);
        #1;
        address = a;
        we      = 1'b0;
        #2;
        rst_n   = 1'b0;
        mdl_scr = '0;
        mdl_wrc = '0;
        mdl_erc = '0;
        push_exp(a, tag);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0, 1: a = 32'h50000 + 4 * (($urandom_range(0, 1) == 0) ?
                      $urandom_range(0, 7) : $urandom_range(1016, 1023));
            2, 3: a = 32'h80000 + 4 * (($urandom_range(0, 1) == 0) ?
                      $urandom_range(0, 7) : $urandom_range(4088, 4095));
            4: a = 32'hC0000 + 4 * $urandom_range(0, 3);
            5: begin
                case ($urandom_range(0, 4))
                    0: a = 32'h51000;
                    1: a = 32'h84000;
                    2: a = 32'h4FFFC;
                    3: a = 32'h7FFFC;
                    default: a = 32'hC000C;
                endcase
            end
            6: a = (32'h1 << $urandom_range(20, 31)) | 32'h50000;
            default: a = $urandom;
        endcase
        if (sel != 7) a = a | 32'($urandom_range(0, 3));
        return a;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            string t;
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            t = tag_q.pop_front();
            checks = checks + 1;
            if (data_out !== e) begin
                errors = errors + 1;
                $display("FAIL %s addr=%h got=%h exp=%h", t, a, data_out, e);
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        mdl_scr = '0;
        mdl_wrc = '0;
        mdl_erc = '0;
        rst_n   = 1'b0;
        address = '0;
        data_in = '0;
        we      = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        op(32'hC0000, 0, 1'b0, "scr_rst");
        op(32'hC0004, 0, 1'b0, "wrc_rst");
        op(32'hC0008, 0, 1'b0, "erc_rst");

        op(32'h50000, 16, 1'b1, "w_dram");
        op(32'h50000, 18, 1'b0, "hold18");
        op(32'h50000, 20, 1'b0, "hold20");
        op(32'hC0004, 0, 1'b0, "wrc1");

        op(32'h80000, 20, 1'b1, "w_fb");
        op(32'h80000, 10, 1'b0, "fb_rd");
        op(32'h50000, 0, 1'b0, "dram_keep");
        op(32'hC0004, 0, 1'b0, "wrc2");

        op(32'h50FFC, 32'hDEAD, 1'b1, "w_last");
        op(32'h51000, 32'hDEAD, 1'b1, "w_past");
        op(32'h50FFC, 0, 1'b0, "rd_last");
        op(32'h51000, 0, 1'b0, "rd_past");
        op(32'hC0008, 0, 1'b0, "erc1");

        op(32'h83FFC, 32'hBEEF, 1'b1, "w_fb_last");
        op(32'h84000, 32'hBEEF, 1'b1, "w_fb_past");
        op(32'h83FFC, 0, 1'b0, "rd_fb_last");
        op(32'h84000, 0, 1'b0, "rd_fb_past");

        op(32'hC0004, 5, 1'b1, "w_ro_wrc");
        op(32'hC0008, 5, 1'b1, "w_ro_erc");
        op(32'hC0004, 0, 1'b0, "wrc_after_ro");
        op(32'hC0008, 0, 1'b0, "erc_after_ro");

        op(32'h10050000, 32'h55, 1'b1, "w_hibit");
        op(32'h50000, 0, 1'b0, "hibit_nohit");
        op(32'h10050000, 0, 1'b0, "rd_hibit");

        op(32'hC0000, 32'h12345678, 1'b1, "w_scr");
        op(32'hC0000, 0, 1'b0, "rd_scr");
        mid_reset(32'hC0000, "scr_midrst");
        op(32'hC0004, 0, 1'b0, "wrc_inrst");
        release_reset();

        op(32'h50000, 7, 1'b1, "w7");
        op(32'h50002, 0, 1'b0, "alias");
        op(32'h50003, 0, 1'b0, "alias3");

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ra;
            ra = rand_addr();
            op(ra, $urandom, 1'($urandom_range(0, 1)), "rand");
        end
        op(32'hC0004, 0, 1'b0, "wrc_end");
        op(32'hC0008, 0, 1'b0, "erc_end");
        op(32'hC0000, 0, 1'b0, "scr_end");

        @(posedge clk);
        #1;
        we = 1'b0;
        repeat (2) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
